// File: rtl/simple_pkg.sv
// Shared definitions for the execution controller.
// Holds the controller state encoding, the phase count and the index of each
// phase within the one-hot phase vector.
package simple_pkg;

  localparam int NPHASE    = 5;
  localparam int PH_FETCH  = 0;
  localparam int PH_DECODE = 1;
  localparam int PH_EXEC   = 2;
  localparam int PH_MEM    = 3;
  localparam int PH_WB     = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

endpackage

// File: rtl/exec_ctl_phase_ring.sv
// phase_ring: one-hot phase rotator p[0] -> p[1] -> ... -> p[NPHASE-1] -> p[0].
// Ports:
//   clk   in   rising-edge clock
//   rst_n in   synchronous active-low reset, returns the ring to p[0]
//   adv   in   advance by one phase this cycle; otherwise hold
//   p     out  registered one-hot phase vector
//   wrap  out  high on the cycle that advances from the last phase to p[0]
module phase_ring
  import simple_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              adv,
  output logic [NPHASE-1:0] p,
  output logic              wrap
);

  logic [NPHASE-1:0] p_q;
  logic [NPHASE-1:0] p_d;

  always_comb begin
    p_d = p_q;
    if (adv) begin
      p_d = {p_q[NPHASE-2:0], p_q[NPHASE-1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_q <= NPHASE'(1);
    end else begin
      p_q <= p_d;
    end
  end

  assign p    = p_q;
  assign wrap = adv & p_q[PH_WB];

endmodule

// File: rtl/exec_ctl.sv
// exec_ctl: run/step/halt/breakpoint controller for a 5-phase instruction cycle.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   run_req      start execution from IDLE, or request a pause while running
//   step_req     execute one instruction from IDLE
//   halt_in      HLT decode flag, meaningful while p[3]=1
//   pc           current program counter
//   bp_en        breakpoint enable
//   bp_addr      breakpoint address
//   p            one-hot phase vector (registered)
//   ce           phase-advance enable (combinational)
//   running      high in RUN or STEP (combinational)
//   halted       high in HALTED (combinational)
//   bp_hit       sticky breakpoint-stop flag (registered)
//   instr_cnt    retired instruction count (registered, wraps)
module exec_ctl
  import simple_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run_req,
  input  logic              step_req,
  input  logic              halt_in,
  input  logic [15:0]       pc,
  input  logic              bp_en,
  input  logic [15:0]       bp_addr,
  output logic [NPHASE-1:0] p,
  output logic              ce,
  output logic              running,
  output logic              halted,
  output logic              bp_hit,
  output logic [15:0]       instr_cnt
);

  state_e      state_q, state_d;
  logic        pause_q, pause_d;
  logic        halt_q, halt_d;
  logic        skip_q, skip_d;
  logic        bp_hit_q, bp_hit_d;
  logic [15:0] cnt_q, cnt_d;

  logic        wrap;
  logic        bp_stop;

  phase_ring u_ring (
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (ce),
    .p     (p),
    .wrap  (wrap)
  );

  // The skip flag lets a resume from a breakpoint address fetch that
  // instruction instead of stopping on it again immediately.
  assign bp_stop = (state_q == ST_RUN) && p[PH_FETCH] && bp_en &&
                   (pc == bp_addr) && !skip_q;

  // Gated by rst_n so no phase strobe fires while reset is being applied.
  assign ce = rst_n && (((state_q == ST_RUN) && !bp_stop) ||
                        (state_q == ST_STEP));

  assign running = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign halted  = (state_q == ST_HALTED);

  always_comb begin
    state_d  = state_q;
    pause_d  = pause_q;
    halt_d   = halt_q;
    skip_d   = skip_q;
    bp_hit_d = bp_hit_q;
    cnt_d    = cnt_q;

    if (wrap) begin
      cnt_d = cnt_q + 16'd1;
    end

    if (running && halt_in && p[PH_MEM]) begin
      halt_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (run_req) begin
          state_d  = ST_RUN;
          skip_d   = 1'b1;
          bp_hit_d = 1'b0;
        end else if (step_req) begin
          state_d  = ST_STEP;
          bp_hit_d = 1'b0;
        end
      end

      ST_RUN: begin
        if (bp_stop) begin
          state_d  = ST_IDLE;
          bp_hit_d = 1'b1;
          pause_d  = 1'b0;
        end else begin
          if (p[PH_FETCH]) begin
            skip_d = 1'b0;
          end
          if (run_req) begin
            pause_d = 1'b1;
          end
          // Boundary priority: halt over pause over continuing.
          if (wrap) begin
            if (halt_q) begin
              state_d = ST_HALTED;
              halt_d  = 1'b0;
              pause_d = 1'b0;
            end else if (pause_q) begin
              state_d = ST_IDLE;
              pause_d = 1'b0;
            end
          end
        end
      end

      ST_STEP: begin
        if (wrap) begin
          if (halt_q) begin
            state_d = ST_HALTED;
            halt_d  = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_HALTED: begin
        state_d = ST_HALTED;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pause_q  <= 1'b0;
      halt_q   <= 1'b0;
      skip_q   <= 1'b0;
      bp_hit_q <= 1'b0;
      cnt_q    <= 16'h0000;
    end else begin
      state_q  <= state_d;
      pause_q  <= pause_d;
      halt_q   <= halt_d;
      skip_q   <= skip_d;
      bp_hit_q <= bp_hit_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bp_hit    = bp_hit_q;
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_exec_ctl.sv
// Testbench for exec_ctl: table-driven cycle vectors plus directed sequences
// for halt, breakpoint/resume/pause and counter wrap.
module tb_exec_ctl;

  logic        clk;
  logic        rst_n;
  logic        run_req;
  logic        step_req;
  logic        halt_in;
  logic [15:0] pc;
  logic        bp_en;
  logic [15:0] bp_addr;
  logic [4:0]  p;
  logic        ce;
  logic        running;
  logic        halted;
  logic        bp_hit;
  logic [15:0] instr_cnt;

  int n_checks;
  int n_fail;

  exec_ctl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run_req   (run_req),
    .step_req  (step_req),
    .halt_in   (halt_in),
    .pc        (pc),
    .bp_en     (bp_en),
    .bp_addr   (bp_addr),
    .p         (p),
    .ce        (ce),
    .running   (running),
    .halted    (halted),
    .bp_hit    (bp_hit),
    .instr_cnt (instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program counter model: advances by one at every instruction boundary.
  always @(posedge clk) begin
    if (!rst_n) pc <= 16'h0000;
    else if (ce && p[4]) pc <= pc + 16'd1;
  end

  typedef struct {
    logic        rst_n;
    logic        run;
    logic        step;
    logic [4:0]  p;
    logic        ce;
    logic        running;
    logic        halted;
    logic        bp_hit;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  int ce_cnt;
  bit found;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    run_req  = 1'b0;
    step_req = 1'b0;
    halt_in  = 1'b0;
    bp_en    = 1'b0;
    bp_addr  = 16'h0000;

    //            rst run stp  p      ce run hlt bp cnt
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 5'b00001, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 5'b00001, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 5'b00010, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 5'b00100, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 5'b01000, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 5'b10000, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 5'b00001, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 5'b00001, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 5'b00010, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 5'b00100, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 5'b01000, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 5'b10000, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 5'b00001, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 5'b00001, 1'b1, 1'b1, 1'b0, 1'b0, 16'd2};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 5'b00010, 1'b1, 1'b1, 1'b0, 1'b0, 16'd2};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 5'b00100, 1'b0, 1'b1, 1'b0, 1'b0, 16'd2};
    tbl[16] = '{1'b1, 1'b0, 1'b0, 5'b00001, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};

    // Table: step twice, then run+step together, then reset mid-instruction.
    tick();
    tick();
    for (int i = 0; i < 17; i++) begin
      rst_n    = tbl[i].rst_n;
      run_req  = tbl[i].run;
      step_req = tbl[i].step;
      #1;
      check($sformatf("vec%0d_p", i),       32'(p),         32'(tbl[i].p));
      check($sformatf("vec%0d_ce", i),      32'(ce),        32'(tbl[i].ce));
      check($sformatf("vec%0d_running", i), 32'(running),   32'(tbl[i].running));
      check($sformatf("vec%0d_halted", i),  32'(halted),    32'(tbl[i].halted));
      check($sformatf("vec%0d_bp_hit", i),  32'(bp_hit),    32'(tbl[i].bp_hit));
      check($sformatf("vec%0d_cnt", i),     32'(instr_cnt), 32'(tbl[i].cnt));
      tick();
    end
    run_req  = 1'b0;
    step_req = 1'b0;

    // Halt at p[3] of the third instruction.
    do_reset();
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    ce_cnt  = 0;
    found   = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (halted) begin
        found = 1'b1;
        break;
      end
      halt_in = (p == 5'b01000) && (instr_cnt == 16'd2);
      #1;
      if (ce) ce_cnt++;
      tick();
    end
    halt_in = 1'b0;
    #1;
    check("halt_reached", 32'(found), 32'd1);
    check("halt_ce_cycles", 32'(ce_cnt), 32'd15);
    check("halt_cnt", 32'(instr_cnt), 32'd3);
    check("halt_p", 32'(p), 32'b00001);
    check("halt_ce", 32'(ce), 32'd0);
    check("halt_running", 32'(running), 32'd0);
    run_req  = 1'b1;
    step_req = 1'b1;
    tick();
    run_req  = 1'b0;
    step_req = 1'b0;
    tick();
    check("halt_ignores_req", 32'(halted), 32'd1);
    check("halt_ignores_ce", 32'(ce), 32'd0);

    // Breakpoint at 0x0004, resume past it, then pause from p[1].
    do_reset();
    bp_en   = 1'b1;
    bp_addr = 16'h0004;
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    found   = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (running && !ce) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("bp_stop_seen", 32'(found), 32'd1);
    check("bp_stop_pc", 32'(pc), 32'h0004);
    check("bp_stop_p", 32'(p), 32'b00001);
    check("bp_stop_cnt", 32'(instr_cnt), 32'd4);
    check("bp_stop_ce", 32'(ce), 32'd0);
    tick();
    check("bp_idle_running", 32'(running), 32'd0);
    check("bp_hit_set", 32'(bp_hit), 32'd1);
    check("bp_idle_p", 32'(p), 32'b00001);
    run_req = 1'b1;
    #1;
    check("bp_idle_ce", 32'(ce), 32'd0);
    tick();
    run_req = 1'b0;
    #1;
    check("resume_ce", 32'(ce), 32'd1);
    check("resume_running", 32'(running), 32'd1);
    check("resume_bp_clear", 32'(bp_hit), 32'd0);
    check("resume_pc", 32'(pc), 32'h0004);
    for (int c = 0; c < 5; c++) tick();
    check("resume_past_pc", 32'(pc), 32'h0005);
    check("resume_past_cnt", 32'(instr_cnt), 32'd5);
    check("resume_past_ce", 32'(ce), 32'd1);
    tick();
    check("pause_at_p1", 32'(p), 32'b00010);
    run_req = 1'b1;
    tick();
    run_req  = 1'b0;
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    check("pause_still_running", 32'(running), 32'd1);
    check("pause_still_p", 32'(p), 32'b01000);
    tick();
    tick();
    check("pause_idle", 32'(running), 32'd0);
    check("pause_p", 32'(p), 32'b00001);
    check("pause_cnt", 32'(instr_cnt), 32'd6);
    check("pause_ce", 32'(ce), 32'd0);
    tick();
    check("pause_holds", 32'(running), 32'd0);
    bp_en = 1'b0;

    // Counter wrap, with halt and pause landing on the same boundary.
    do_reset();
    force dut.cnt_q = 16'hFFFF;
    #1;
    release dut.cnt_q;
    #1;
    check("wrap_preset", 32'(instr_cnt), 32'hFFFF);
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    found   = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (halted) begin
        found = 1'b1;
        break;
      end
      run_req = (p == 5'b00010);
      halt_in = (p == 5'b01000);
      tick();
    end
    run_req = 1'b0;
    halt_in = 1'b0;
    #1;
    check("wrap_halted", 32'(found), 32'd1);
    check("wrap_cnt", 32'(instr_cnt), 32'h0000);
    check("wrap_p", 32'(p), 32'b00001);
    check("wrap_ce", 32'(ce), 32'd0);
    check("wrap_running", 32'(running), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

endmodule
